// File: rtl/i2c_dac_transmitter_if.sv
// i2c_dac_transmitter_if: sample handshake, status flags and open-drain I2C enables
//   sample/sample_valid/sample_ready/busy : one-sample-per-transaction handshake
//   done/nack_error                       : transaction end pulse and missing-ACK flag
//   scl_oe/sda_oe                         : 1 = pull line low, 0 = release
//   sda_i                                 : SDA pad level seen by the transmitter
interface i2c_dac_transmitter_if;
    logic [7:0] sample;
    logic       sample_valid;
    logic       sample_ready;
    logic       busy;
    logic       done;
    logic       nack_error;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_i;
    modport master (
        output sample, sample_valid, sda_i,
        input  sample_ready, busy, done, nack_error, scl_oe, sda_oe
    );
    modport slave (
        input  sample, sample_valid, sda_i,
        output sample_ready, busy, done, nack_error, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_dac_transmitter.sv
// i2c_dac_transmitter: writes each accepted sample to an I2C DAC as address, control, data bytes
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave side of i2c_dac_transmitter_if (handshake, status, SCL/SDA enables)
module i2c_dac_transmitter #(
    parameter int         CLK_DIV   = 4,
    parameter logic [6:0] DEV_ADDR  = 7'h48,
    parameter logic [7:0] CTRL_BYTE = 8'h40
) (
    input logic clk,
    input logic reset,
    i2c_dac_transmitter_if.slave bus
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;
    state_t      state, state_n;
    logic [DW-1:0] div;
    logic [1:0]  q, q_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [1:0]  byte_idx, byte_n;
    logic [7:0]  data_q, cur_byte;
    logic        nack_q, nack_n, done_q, done_n, scl_q, scl_n, sda_q, sda_n;
    logic        tick, accept;

    assign accept           = state == IDLE && bus.sample_valid;
    assign tick             = state != IDLE && div == DW'(CLK_DIV - 1);
    assign bus.sample_ready = state == IDLE;
    assign bus.busy         = state != IDLE;
    assign bus.done         = done_q;
    assign bus.nack_error   = nack_q;
    assign bus.scl_oe       = scl_q;
    assign bus.sda_oe       = sda_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            q        <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            div      <= '0;
            nack_q   <= 1'b0;
            done_q   <= 1'b0;
            scl_q    <= 1'b0;
            sda_q    <= 1'b0;
        end else begin
            state    <= state_n;
            q        <= q_n;
            bit_cnt  <= bit_n;
            byte_idx <= byte_n;
            div      <= (state == IDLE || tick) ? '0 : div + DW'(1);
            nack_q   <= nack_n;
            done_q   <= done_n;
            scl_q    <= scl_n;
            sda_q    <= sda_n;
        end
    end

    always_ff @(posedge clk)
        if (accept) data_q <= bus.sample;

    // Byte and bit that will be on the bus after this edge; the line enables
    // are registered from the next state so they change with the slot itself.
    assign cur_byte = byte_n == 2'd0 ? {DEV_ADDR, 1'b0} : byte_n == 2'd1 ? CTRL_BYTE : data_q;

    always_comb begin
        state_n = state;
        q_n     = tick ? q + 2'd1 : q;
        bit_n   = bit_cnt;
        byte_n  = byte_idx;
        nack_n  = nack_q;
        done_n  = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_n = START;
                nack_n  = 1'b0;
            end
            START: if (tick && q == 2'd3) begin
                state_n = BIT;
                bit_n   = '0;
                byte_n  = '0;
            end
            BIT: if (tick && q == 2'd3) begin
                if (bit_cnt == 3'd7) state_n = ACK;
                else bit_n = bit_cnt + 3'd1;
            end
            ACK: if (tick) begin
                if (q == 2'd2 && bus.sda_i) nack_n = 1'b1;
                if (q == 2'd3) begin
                    // A NACK or the final data ACK both end the frame.
                    if (nack_q || byte_idx == 2'd2) state_n = STOP;
                    else begin
                        state_n = BIT;
                        bit_n   = '0;
                        byte_n  = byte_idx + 2'd1;
                    end
                end
            end
            STOP: if (tick && q == 2'd3) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        scl_n = (state_n == BIT || state_n == ACK) ? ~q_n[1] : state_n == STOP ? q_n == 2'd0 : 1'b0;
        sda_n = state_n == START ? q_n[1] : state_n == BIT ? ~cur_byte[~bit_n] :
                state_n == STOP ? ~q_n[1] : 1'b0;
    end
endmodule

// File: doc/i2c_dac_transmitter.md
Name: i2c_dac_transmitter

Overview:
Downstream consumer of the signal generator's 8-bit output (signal[31:24]). It accepts one sample per handshake and writes it to an external I2C DAC (PCF8591-style) as a 3-byte write: address byte, control byte, data byte. It generates SCL/SDA open-drain enables from a single system clock using an internal quarter-period divider. A nack_error flag reports a missing DAC acknowledge.

Parameters:
CLK_DIV, 4, clk cycles per SCL quarter-period; must be >= 1
DEV_ADDR, 7'h48, 7-bit I2C device address
CTRL_BYTE, 8'h40, control byte sent before the data (DAC output enable)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sample  input  8  DAC code to transmit
sample_valid  input  1  sample offered
sample_ready  output  1  high in IDLE; accept happens when valid && ready
busy  output  1  transaction in progress (= !sample_ready)
done  output  1  one-cycle pulse at transaction end (ACK or NACK)
nack_error  output  1  set on any NACK; cleared on next accept
scl_oe  output  1  1 = pull SCL low; 0 = release
sda_oe  output  1  1 = pull SDA low; 0 = release
sda_i  input  1  SDA line as read from the pad

Behaviour:
- Single clock domain. Reset is synchronous and active-high: state=IDLE, scl_oe=0, sda_oe=0, done=0, nack_error=0, divider=0. sample_ready=1 on the first cycle after reset deasserts.
- All outputs are registered except sample_ready and busy, which are decoded from the state register.
- Accept: sample latched into shift register; nack_error cleared; divider cleared. Input changes and further sample_valid pulses are ignored until IDLE.
- Divider: counts 0..CLK_DIV-1 while not IDLE. A tick occurs at count CLK_DIV-1. Each tick advances one quarter (Q0..Q3). 4 quarters form one slot.
- Slot sequence: START, ADDR(8), ACK, CTRL(8), ACK, DATA(8), ACK, STOP. That is 29 slots.
- START slot: SCL released all 4 quarters. SDA released Q0-Q1, pulled low Q2-Q3.
- Data bit slot: SCL low Q0-Q1, released Q2-Q3. sda_oe = ~bit, set at the start of Q0 and held the whole slot. Bits go out MSB first.
- ADDR byte = {DEV_ADDR,1'b0}. Then CTRL_BYTE, then the latched sample.
- ACK slot: SDA released. SCL pattern is the same as a data bit. sda_i is sampled on the tick ending Q2. A sampled value of 1 is a NACK.
- NACK: set nack_error. Skip the remaining bytes and go directly to the STOP slot.
- STOP slot: sda_oe=1 all slots quarters until Q2. SCL low in Q0, released Q1-Q3. SDA released in Q2-Q3.
- End of STOP: on the tick ending STOP Q3, the next edge returns to IDLE and asserts done for exactly 1 cycle. sample_ready is high that same cycle.
- Latency: full transaction is 116*CLK_DIV cycles from accept edge to done. Address NACK takes 11 slots = 44*CLK_DIV cycles.
- Back-to-back: if valid is high in the done cycle, the next transaction is accepted that cycle with no extra idle.
- Reset mid-transaction: the next edge releases both lines and enters IDLE. No STOP is generated, done stays 0, and nack_error is cleared.
- A counter for bits within a byte (0..7) and a byte index (0..2) control sequencing. There is no wrap beyond byte 2.

Test Plan:
1. Reset held 3 cycles, then released -> scl_oe=sda_oe=0, done=0, nack_error=0, sample_ready=1 on the first post-reset cycle.
2. CLK_DIV=4, sample=8'hA5, bench drives sda_i=0 in ACK slots -> decoded bus bytes are 0x90, 0x40, 0xA5 with START/STOP framing. done pulses 464 cycles after accept and nack_error=0.
3. sda_i held 1 (no device), sample=8'h3C -> STOP follows the first ACK slot. done is 176 cycles after accept, nack_error=1, and the CTRL byte is never driven.
4. sample_valid held high with sample incrementing on each accept -> the second accept coincides with the first done cycle. The second frame's START begins with no gap and carries the new value.
5. During a transfer, change sample and pulse sample_valid -> transmitted data equals the value latched at accept. No extra transaction occurs and sample_ready stays 0 until done.
6. Assert reset during DATA bit 3 -> next cycle scl_oe=sda_oe=0 and state is IDLE. No done pulse, nack_error=0, and a new accept afterwards produces a correct full frame.
